// File: rtl/ycfsm_sync_array_if.sv
// Dual-rail token bus between the token fabric/controller and a ycfsm_sync_array row.
// The controller drives in/match; the cell row returns per-lane results and aggregate flags.
interface ycfsm_sync_array_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 8
);
  logic [2*LANES-1:0] in;
  logic [2*LANES-1:0] match;
  logic [2*LANES-1:0] out;
  logic               done;
  logic               all_match;
  logic               err;
  logic [CNT_W-1:0]   miss_count;

  modport master (
    output in, match,
    input  out, done, all_match, err, miss_count
  );

  modport slave (
    input  in, match,
    output out, done, all_match, err, miss_count
  );
endinterface

// File: rtl/ycfsm_sync_array.sv
// Row of LANES independent clocked dual-rail match cells with aggregate flags.
// Optional saturating miss counter is built only when YCFSM_MISS_CNT_EN is defined.
module ycfsm_sync_array #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  ycfsm_sync_array_if.slave   bus
);

  // State codes equal the out encoding, so out is the state register itself.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_MISS  = 2'b01,
    S_HIT   = 2'b10,
    S_ERR   = 2'b11
  } state_t;

  state_t st  [LANES];
  state_t nxt [LANES];

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      nxt[i] = st[i];
      case (st[i])
        S_EMPTY: begin
          if (bus.in[2*i +: 2] == 2'b11 || bus.match[2*i +: 2] == 2'b11)
            nxt[i] = S_ERR;
          else if (^bus.in[2*i +: 2] && ^bus.match[2*i +: 2])
            nxt[i] = (bus.in[2*i +: 2] == bus.match[2*i +: 2]) ? S_HIT : S_MISS;
        end
        S_HIT, S_MISS: begin
          if (bus.in[2*i +: 2] == 2'b11)
            nxt[i] = S_ERR;
          else if (bus.in[2*i +: 2] == 2'b00)
            nxt[i] = S_EMPTY;
        end
        default: nxt[i] = S_ERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LANES; i++)
        st[i] <= S_EMPTY;
    end else begin
      for (int unsigned i = 0; i < LANES; i++)
        st[i] <= nxt[i];
    end
  end

  always_comb begin
    bus.out       = '0;
    bus.done      = 1'b1;
    bus.all_match = 1'b1;
    bus.err       = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      bus.out[2*i +: 2] = st[i];
      if (st[i] != S_HIT && st[i] != S_MISS)
        bus.done = 1'b0;
      if (st[i] != S_HIT)
        bus.all_match = 1'b0;
      if (st[i] == S_ERR)
        bus.err = 1'b1;
    end
  end

`ifdef YCFSM_MISS_CNT_EN
  localparam int unsigned IW = 6;

  logic [IW-1:0]       miss_inc;
  logic [CNT_W+IW-1:0] cnt_sum;
  logic [CNT_W-1:0]    cnt;

  always_comb begin
    miss_inc = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (st[i] == S_EMPTY && nxt[i] == S_MISS)
        miss_inc = miss_inc + IW'(1);
    end
    cnt_sum = (CNT_W+IW)'(cnt) + (CNT_W+IW)'(miss_inc);
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (cnt_sum > (CNT_W+IW)'({CNT_W{1'b1}}))
      cnt <= '1;
    else
      cnt <= cnt_sum[CNT_W-1:0];
  end

  assign bus.miss_count = cnt;
`else
  assign bus.miss_count = '0;
`endif

endmodule

// File: doc/ycfsm_sync_array.md
Name: ycfsm_sync_array

Overview:
- Synchronous, parametrised successor of the single asynchronous Morphle Logic match cell FSM.
- Holds LANES independent dual-rail match cells. Each cell compares an input token against a match token and latches a HIT/MISS result until the input returns to empty (return-to-zero handshake).
- Provides aggregate done/all-match/error flags so a controller can sequence a whole row of cells on one clock.
- Sits between the dual-rail token fabric and the clocked test/config controller.

Parameters:
- LANES, 4, number of independent match cells (1..32).
- CNT_W, 8, width of miss_count (used only with YCFSM_MISS_CNT_EN).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on clk rising edge, clears all state.
- in  input  2*LANES  dual-rail input tokens; lane i = in[2i+1:2i].
- match  input  2*LANES  dual-rail match tokens; lane i = match[2i+1:2i].
- out  output  2*LANES  dual-rail result per lane; lane i = out[2i+1:2i].
- done  output  1  every lane in HIT or MISS.
- all_match  output  1  done and every lane in HIT.
- err  output  1  at least one lane in ERR.
- miss_count  output  CNT_W  saturating count of MISS entries (see Optional Feature).

Behaviour:
- Token encoding (in, match, out): 00 = empty, 01 = logic 0, 10 = logic 1, 11 = illegal.
- Per-lane state machine: states EMPTY, HIT, MISS, ERR. Out encoding per state: EMPTY 00, HIT 10, MISS 01, ERR 11.
- Reset: synchronous and highest priority. All lanes go to EMPTY; out = 0, done = 0, all_match = 0, err = 0, miss_count = 0 on the cycle after the reset edge.
- EMPTY:
  - in==11 or match==11 -> ERR.
  - Else, in valid and match valid: equal -> HIT, different -> MISS.
  - Else (either token empty) -> stay EMPTY.
- HIT/MISS:
  - in==11 -> ERR.
  - Else in==00 -> EMPTY.
  - Else hold. Changes on match, or to another valid in value, are ignored (result is latched).
- ERR: sticky; exits only via reset.
- Latency: inputs sampled at edge k appear on out at edge k. This is one registered stage, with no combinational path from in/match to out.
- done, all_match and err are decoded combinationally from the lane state registers. They are therefore aligned with out, with no extra latency.
- Lanes are fully independent. Simultaneous transitions in different lanes in one cycle are all taken.
- A lane going EMPTY->HIT/MISS in the same cycle another lane returns to EMPTY is legal. done reflects the post-edge states.
- Back-to-back tokens: a new token needs at least one cycle of in==00. A direct change from 01 to 10 while in HIT/MISS is held, not re-evaluated.
- Reset mid-operation (any lane HIT/MISS/ERR) returns all lanes to EMPTY on the next edge, regardless of in/match.

Optional Feature:
- Macro: YCFSM_MISS_CNT_EN.
- Defined:
  - miss_count increments on each edge by the number of lanes transitioning EMPTY->MISS on that edge.
  - Saturates at 2^CNT_W-1; never wraps.
  - Cleared only by reset. HIT and ERR transitions do not count.
- Undefined: no counter logic is built; miss_count is tied to 0. The port list is unchanged.

Test Plan:
- All scenarios use LANES=4, CNT_W=8.
- Reset held 2 cycles with in=8'hFF, match=8'hFF -> out=0, done=0, err=0, miss_count=0 after the reset edge.
- in=8'b10_01_10_01, match=8'b10_01_10_01 -> next edge out=8'hAA, done=1, all_match=1. Then match changed to 8'h55 while in held -> out stays 8'hAA.
- Same in, match=8'b01_01_10_01 -> out=8'b01_10_10_10, done=1, all_match=0, miss_count=1 (0 with macro off). Then in=0 -> out=0, done=0 next edge.
- Lane 2 only: in[5:4]=10, match[5:4]=00 for 3 cycles -> out[5:4]=00. Then match[5:4]=10 -> out[5:4]=10 next edge, done=0 (other lanes empty).
- Lane 1 in=11 -> out[3:2]=11, err=1. Then in=0 -> still 11, err=1. Then reset -> out=0, err=0.
- Macro on, CNT_W=2, all 4 lanes mismatching per token, 2 tokens with in=0 between -> miss_count 3 (saturated after first token's 4), stays 3.
